eth_tx_mac: RTL and testbench

ETH_TX_MAC -- requirements
Module: eth_tx_mac

---
 rtl/eth_tx_mac.sv | 197 +++++++++++++++++++
 tb/tb_eth_tx_mac.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_mac.sv
// Manchester-coded Ethernet-style frame transmitter: preamble, SFD, payload, optional FCS, TP_IDLE.
// Define ETH_TX_FCS_EN to append a CRC-32 frame check sequence after the payload.
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_IDLE     | line off, waiting for start
// S_PREAMBLE | PRE_BYTES x 0x55, then SFD 0xD5
// S_DATA     | payload bytes loaded on tx_ready & tx_valid
// S_FCS      | four complemented CRC bytes (ETH_TX_FCS_EN only)
// S_TPIDLE   | line held high, then done pulse on return to idle

module eth_tx_mac #(
  parameter int CLK_PER_HALF = 1,
  parameter int PRE_BYTES    = 7,
  parameter int MAX_LEN      = 1500,
  parameter int TPIDLE_HALF  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       eth_tx_d,
  output logic       eth_tx_en,
  output logic       busy,
  output logic       done,
  output logic       err_underrun,
  output logic       err_len
);

  localparam int BW     = $clog2(MAX_LEN + 1);
  localparam int TP_CYC = TPIDLE_HALF * CLK_PER_HALF;
  localparam int TW     = $clog2(TP_CYC + 1);

  localparam logic [7:0]    DIV_LD   = 8'(CLK_PER_HALF - 1);
  localparam logic [TW-1:0] TP_LD    = TW'(TP_CYC - 1);
  localparam logic [BW-1:0] LEN_M1   = BW'(MAX_LEN - 1);
  localparam logic [2:0]    PRE_LAST = 3'(PRE_BYTES - 1);
  localparam logic [2:0]    PRE_SFD  = 3'(PRE_BYTES);

`ifdef ETH_TX_FCS_EN
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_FCS, S_TPIDLE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_TPIDLE} state_t;
`endif

  state_t        state;
  logic [7:0]    div_cnt;
  logic [3:0]    half_idx;
  logic [7:0]    cur_byte;
  logic [2:0]    pre_cnt;
  logic [BW-1:0] byte_cnt;
  logic          cur_last;
  logic [TW-1:0] tp_cnt;

  logic       half_end, byte_end, len_hit, nxt_half;
  logic [3:0] nxt_idx;

  assign half_end = (div_cnt == 8'd0);
  assign byte_end = half_end && (half_idx == 4'd15);
  assign len_hit  = (byte_cnt == LEN_M1);
  assign nxt_idx  = half_idx + 4'd1;
  assign nxt_half = nxt_idx[0] ? cur_byte[nxt_idx[3:1]] : ~cur_byte[nxt_idx[3:1]];

  // Strobes are decoded from registered state so they land in the byte's final cycle.
  assign tx_ready = byte_end &&
                    ((state == S_PREAMBLE && pre_cnt == PRE_SFD) ||
                     (state == S_DATA && !cur_last));
  assign err_underrun = tx_ready && !tx_valid;
  assign err_len      = tx_ready && tx_valid && !tx_last && len_hit;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc, crc_inv;
  logic [1:0]  fcs_idx, fcs_nxt_idx;
  logic [7:0]  fcs_nxt;

  assign crc_inv     = ~crc;
  assign fcs_nxt_idx = fcs_idx + 2'd1;
  assign fcs_nxt     = crc_inv[{fcs_nxt_idx, 3'b000} +: 8];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      half_idx  <= '0;
      cur_byte  <= '0;
      pre_cnt   <= '0;
      byte_cnt  <= '0;
      cur_last  <= 1'b0;
      tp_cnt    <= '0;
      eth_tx_d  <= 1'b0;
      eth_tx_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ETH_TX_FCS_EN
      crc       <= '0;
      fcs_idx   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          byte_cnt  <= '0;
          cur_last  <= 1'b0;
          eth_tx_d  <= 1'b0;
          eth_tx_en <= 1'b0;
          busy      <= 1'b0;
`ifdef ETH_TX_FCS_EN
          crc       <= 32'hFFFF_FFFF;
`endif
          if (start) begin
            state     <= S_PREAMBLE;
            pre_cnt   <= '0;
            cur_byte  <= 8'h55;
            half_idx  <= '0;
            div_cnt   <= DIV_LD;
            eth_tx_d  <= 1'b0;
            eth_tx_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_TPIDLE: begin
          if (tp_cnt == '0) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            eth_tx_en <= 1'b0;
            busy      <= 1'b0;
            eth_tx_d  <= 1'b0;
          end else begin
            tp_cnt <= tp_cnt - 1'b1;
          end
        end
        default: begin
          if (!half_end) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LD;
            if (half_idx != 4'd15) begin
              half_idx <= nxt_idx;
              eth_tx_d <= nxt_half;
            end else begin
              half_idx <= '0;
              if (tx_ready) begin
                if (tx_valid) begin
                  state    <= S_DATA;
                  cur_byte <= tx_data;
                  eth_tx_d <= ~tx_data[0];
                  byte_cnt <= byte_cnt + 1'b1;
                  cur_last <= tx_last || len_hit;
`ifdef ETH_TX_FCS_EN
                  crc      <= crc_byte(crc, tx_data);
`endif
                end else begin
                  state    <= S_TPIDLE;
                  eth_tx_d <= 1'b1;
                  tp_cnt   <= TP_LD;
                end
              end else if (state == S_PREAMBLE) begin
                pre_cnt  <= pre_cnt + 3'd1;
                cur_byte <= (pre_cnt == PRE_LAST) ? 8'hD5 : 8'h55;
                eth_tx_d <= 1'b0;  // 0x55 and 0xD5 both start with a 1 bit
              end
`ifdef ETH_TX_FCS_EN
              else if (state == S_DATA) begin
                state    <= S_FCS;
                fcs_idx  <= '0;
                cur_byte <= crc_inv[7:0];
                eth_tx_d <= crc[0];
              end else if (fcs_idx != 2'd3) begin
                fcs_idx  <= fcs_nxt_idx;
                cur_byte <= fcs_nxt;
                eth_tx_d <= ~fcs_nxt[0];
              end
`endif
              else begin
                state    <= S_TPIDLE;
                eth_tx_d <= 1'b1;
                tp_cnt   <= TP_LD;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_mac.sv
// Randomized bench for eth_tx_mac: frames are checked cycle by cycle against a byte-list line model.
module tb_eth_tx_mac;
  localparam int CPH  = 2;
  localparam int PRE  = 3;
  localparam int MAXL = 9;
  localparam int TPH  = 5;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic       tx_ready, eth_tx_d, eth_tx_en, busy, done, err_underrun, err_len;

  always #5 clk = ~clk;

  eth_tx_mac #(.CLK_PER_HALF(CPH), .PRE_BYTES(PRE), .MAX_LEN(MAXL), .TPIDLE_HALF(TPH)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .eth_tx_d(eth_tx_d), .eth_tx_en(eth_tx_en),
    .busy(busy), .done(done), .err_underrun(err_underrun), .err_len(err_len)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [7:0] off_d[$];
  bit         off_v[$];
  bit         off_l[$];
  logic [7:0] exp_b[$];
  int         exp_acc;
  bit         exp_und, exp_elen;
  bit         cap_d[$];

  task automatic drive_offer(input int k);
    if (k < off_d.size()) begin
      tx_valid = off_v[k]; tx_data = off_d[k]; tx_last = off_l[k];
    end else begin
      tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    end
  endtask

  // Frame = preamble + SFD + accepted payload (+ FCS unless truncated by underrun).
  task automatic build_expect();
    logic [7:0] pl[$];
    exp_b.delete();
    for (int i = 0; i < PRE; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    exp_und = 0; exp_elen = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k >= off_d.size() || !off_v[k]) begin exp_und = 1; break; end
      pl.push_back(off_d[k]);
      if (off_l[k]) break;
      if (pl.size() == MAXL) begin exp_elen = 1; break; end
    end
    exp_acc = pl.size();
    foreach (pl[i]) exp_b.push_back(pl[i]);
`ifdef ETH_TX_FCS_EN
    if (!exp_und) begin
      logic [31:0] c;
      logic fb;
      c = 32'hFFFF_FFFF;
      foreach (pl[i])
        for (int b = 0; b < 8; b++) begin
          fb = c[0] ^ pl[i][b];
          c = c >> 1;
          if (fb) c = c ^ 32'hEDB8_8320;
        end
      c = ~c;
      for (int j = 0; j < 4; j++) exp_b.push_back(8'((c >> (8 * j)) & 32'hFF));
    end
`endif
  endtask

  function automatic int exp_d_at(input int idx);
    int line_cyc, h, bt;
    logic [7:0] b;
    line_cyc = 16 * exp_b.size() * CPH;
    if (idx < line_cyc) begin
      h  = idx / CPH;
      b  = exp_b[h / 16];
      bt = (h % 16) / 2;
      return (h % 2 == 1) ? int'(b[bt]) : int'(!b[bt]);
    end
    if (idx < line_cyc + TPH * CPH) return 1;
    return 2;
  endfunction

  task automatic run_frame(input int abort_at, input bit poke_start);
    int cyc, oi, en_cnt, dmis, und_cnt, len_cnt, rdy_cnt;
    bit got_done, rdy;
    build_expect();
    oi = 0; cyc = 0; en_cnt = 0; dmis = 0; und_cnt = 0; len_cnt = 0; rdy_cnt = 0;
    got_done = 0;
    cap_d.delete();
    drive_offer(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 6000) begin
      @(negedge clk);
      if (cyc == 0) check("first_en_busy", 32'({eth_tx_en, busy}), 32'h3);
      if (eth_tx_en) begin
        if (int'(eth_tx_d) != exp_d_at(en_cnt)) dmis++;
        cap_d.push_back(eth_tx_d);
        en_cnt++;
      end
      und_cnt += int'(err_underrun);
      len_cnt += int'(err_len);
      rdy_cnt += int'(tx_ready);
      if (done) begin
        check("done_cycle_en_busy", 32'({eth_tx_en, busy}), 32'h0);
        got_done = 1;
        break;
      end
      rdy = tx_ready;
      @(posedge clk); #1;
      if (rdy) begin oi++; drive_offer(oi); end
      start = poke_start && (cyc == 40 || cyc == 41);
      cyc++;
      if (abort_at > 0 && cyc == abort_at) begin
        reset = 1'b1;
        #1;
        check("reset_outs_zero", 32'({tx_ready, eth_tx_d, eth_tx_en, busy, done, err_underrun, err_len}), 32'h0);
        start = 1'b0; tx_valid = 1'b0;
        return;
      end
    end
    start = 1'b0; tx_valid = 1'b0;
    check("done_seen", 32'(got_done), 32'h1);
    check("en_cycles", en_cnt, 16 * exp_b.size() * CPH + TPH * CPH);
    check("line_d_errors", dmis, 0);
    check("ready_pulses", rdy_cnt, exp_acc + int'(exp_und));
    check("underrun_pulses", und_cnt, int'(exp_und));
    check("len_pulses", len_cnt, int'(exp_elen));
    @(negedge clk);
    check("idle_after_done", 32'({eth_tx_en, busy, eth_tx_d, done}), 32'h0);
  endtask

  task automatic clear_offers();
    off_d.delete(); off_v.delete(); off_l.delete();
  endtask

  task automatic add_offer(input logic [7:0] d, input bit v, input bit l);
    off_d.push_back(d); off_v.push_back(v); off_l.push_back(l);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({tx_ready, eth_tx_d, eth_tx_en, busy, done, err_underrun, err_len}), 32'h0);
    reset = 1'b0;

    clear_offers();
    add_offer(8'hA5, 1, 1);
    run_frame(0, 0);
    check("first_half_bit0", 32'(cap_d[0]), 32'h0);
    check("second_half_bit0", 32'(cap_d[CPH]), 32'h1);

    clear_offers();
    add_offer(8'h3C, 1, 0);
    add_offer(8'h77, 0, 1);
    run_frame(0, 0);

    clear_offers();
    for (int k = 0; k < MAXL + 2; k++) add_offer(8'(k * 17 + 3), 1, 0);
    run_frame(0, 0);

`ifdef ETH_TX_FCS_EN
    begin
      logic [7:0] fcs_exp [4];
      logic [7:0] got;
      fcs_exp = '{8'h26, 8'h39, 8'hF4, 8'hCB};
      clear_offers();
      for (int k = 0; k < 9; k++) add_offer(8'(8'h31 + k), 1, k == 8);
      run_frame(0, 0);
      for (int j = 0; j < 4; j++) begin
        for (int i = 0; i < 8; i++)
          got[i] = ((16 * (PRE + 10 + j) + 2 * i + 1) * CPH < cap_d.size()) ?
                   cap_d[(16 * (PRE + 10 + j) + 2 * i + 1) * CPH] : 1'b0;
        check("fcs_byte", 32'(got), 32'(fcs_exp[j]));
      end
    end
`endif

    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, MAXL + 2);
      clear_offers();
      for (int k = 0; k < len; k++)
        add_offer(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0, k == len - 1);
      run_frame(0, bit'($urandom_range(0, 1)));
    end

    clear_offers();
    for (int k = 0; k < 6; k++) add_offer(8'(8'hC0 + k), 1, k == 5);
    run_frame((PRE + 1) * 16 * CPH + 40, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_offers();
    for (int k = 0; k < 4; k++) add_offer(8'(8'h5A ^ k), 1, k == 3);
    run_frame(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
